// File: rtl/bmem_copy_engine.sv
// bmem_copy_engine
//
// Bus-initiator copy engine. On a start command it reads a block of 32-bit
// words from a source region (normally boot memory) and writes them to a
// destination region (normally main memory) over a single dbus initiator
// port using the req/ack handshake. One read and one write per word.
//
// Optional feature macro: BMEM_COPY_TIMEOUT_EN
//   defined   : each bus access is aborted after TIMEOUT cycles without ack;
//               the engine then pulses err_o instead of done_o.
//   undefined : the engine waits indefinitely for ack; err_o is tied 0.
//
// Parameters
//   XLEN    address/data width
//   CNT_W   width of the word-count field
//   TIMEOUT ack wait limit in cycles (timeout build only)
//
// Ports
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   start_i        start command, sampled in IDLE only
//   src_addr_i     source byte address (bits [1:0] ignored)
//   dst_addr_i     destination byte address (bits [1:0] ignored)
//   word_cnt_i     number of words to copy
//   busy_o         high in RD, WR and FIN
//   done_o         one-cycle pulse on successful completion
//   err_o          one-cycle pulse on timeout abort
//   dbus_req_o     bus request, dropped combinationally in the ack cycle
//   dbus_addr_o    bus address
//   dbus_w_en_o    1 = write, 0 = read
//   dbus_w_data_o  write data
//   dbus_ack_i     responder ack (registered at the responder)
//   dbus_r_data_i  read data, valid in the ack cycle
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start_i
// RD    | reading the word at src from the bus
// WR    | writing the captured word to dst
// FIN   | one-cycle done_o / err_o pulse, then back to IDLE

module bmem_copy_engine #(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [XLEN-1:0] src_addr_i,
    input  logic [XLEN-1:0] dst_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            dbus_req_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic            dbus_w_en_o,
    output logic [XLEN-1:0] dbus_w_data_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_r_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Addresses are kept as word addresses so the +4 step and the 2^XLEN
    // wrap fall out of plain increment arithmetic.
    logic [XLEN-3:0]  src_q;
    logic [XLEN-3:0]  dst_q;
    logic [XLEN-1:0]  data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_xfer;
    logic             timeout_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    assign in_xfer = (state_q == S_RD) || (state_q == S_WR);

`ifdef BMEM_COPY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_q;
    logic          err_q;

    // Down-counter reloaded on every entry into RD/WR; the access is given
    // up in the cycle it has already been waited on TIMEOUT times.
    assign timeout_hit = in_xfer && !dbus_ack_i && (wait_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (((state_d == S_RD) || (state_d == S_WR)) && (state_d != state_q)) begin
            wait_q <= WAIT_LOAD;
        end else if (in_xfer && !dbus_ack_i && (wait_q != '0)) begin
            wait_q <= wait_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (word_cnt_i == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                if (dbus_ack_i) begin
                    state_d = S_WR;
                end else if (timeout_hit) begin
                    state_d = S_FIN;
                end
            end
            S_WR: begin
                if (dbus_ack_i) begin
                    // cnt_q == 1 means the decremented count reaches zero.
                    state_d = (cnt_q == CNT_W'(1)) ? S_FIN : S_RD;
                end else if (timeout_hit) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && (word_cnt_i != '0)) begin
                        src_q <= src_addr_i[XLEN-1:2];
                        dst_q <= dst_addr_i[XLEN-1:2];
                        cnt_q <= word_cnt_i;
                    end
                end
                S_RD: begin
                    if (dbus_ack_i) begin
                        data_q <= dbus_r_data_i;
                    end
                end
                S_WR: begin
                    if (dbus_ack_i) begin
                        src_q <= src_q + 1'b1;
                        dst_q <= dst_q + 1'b1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address/data come straight from registers that only change on ack,
    // so they stay stable for as long as req is held.
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = 1'b0;
        err_o         = 1'b0;
        dbus_req_o    = 1'b0;
        dbus_addr_o   = '0;
        dbus_w_en_o   = 1'b0;
        dbus_w_data_o = '0;
        case (state_q)
            S_RD: begin
                dbus_req_o  = ~dbus_ack_i;
                dbus_addr_o = {src_q, 2'b00};
            end
            S_WR: begin
                dbus_req_o    = ~dbus_ack_i;
                dbus_addr_o   = {dst_q, 2'b00};
                dbus_w_en_o   = 1'b1;
                dbus_w_data_o = data_q;
            end
            S_FIN: begin
`ifdef BMEM_COPY_TIMEOUT_EN
                done_o = ~err_q;
                err_o  = err_q;
`else
                done_o = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bmem_copy_engine.sv
module tb_bmem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] word_cnt_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        dbus_req_o;
    logic [31:0] dbus_addr_o;
    logic        dbus_w_en_o;
    logic [31:0] dbus_w_data_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_r_data_i;

    int total = 0;
    int bad   = 0;

    bmem_copy_engine #(.XLEN(32), .CNT_W(16), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .src_addr_i    (src_addr_i),
        .dst_addr_i    (dst_addr_i),
        .word_cnt_i    (word_cnt_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .dbus_req_o    (dbus_req_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_w_en_o   (dbus_w_en_o),
        .dbus_w_data_o (dbus_w_data_o),
        .dbus_ack_i    (dbus_ack_i),
        .dbus_r_data_i (dbus_r_data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    xact_t exp_q[$];

    // 0 = never ack; n = ack in the cycle after the n-th req cycle
    int resp_lat = 1;
    int done_cnt = 0;

    // Registered responder: compares each completed access against the
    // scoreboard and checks that req/addr/w_en/w_data hold while waiting.
    int          wc   = 0;
    bit          held = 0;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic        h_we;

    always @(posedge clk) begin
        if (dbus_ack_i) begin
            dbus_ack_i <= 1'b0;
            wc   = 0;
            held = 0;
        end else if (dbus_req_o) begin
            if (!held) begin
                held   = 1;
                h_addr = dbus_addr_o;
                h_data = dbus_w_data_o;
                h_we   = dbus_w_en_o;
            end else begin
                chk("hold_addr", dbus_addr_o, h_addr);
                chk("hold_we", dbus_w_en_o, h_we);
                chk("hold_wdata", dbus_w_data_o, h_data);
            end
            wc++;
            if (resp_lat != 0 && wc >= resp_lat) begin
                xact_t e;
                dbus_ack_i <= 1'b1;
                held = 0;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_access", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_we", dbus_w_en_o, e.we);
                    chk("bus_addr", dbus_addr_o, e.addr);
                    if (e.we) chk("bus_wdata", dbus_w_data_o, e.data);
                end
                if (!dbus_w_en_o) dbus_r_data_i <= pat(dbus_addr_o);
                else              dbus_r_data_i <= 32'hDEAD_BEEF;
            end
        end else begin
            held = 0;
            wc   = 0;
        end
    end

    always @(negedge clk) begin
        if (dbus_ack_i) chk("req_drop_in_ack", dbus_req_o, 0);
        if (done_o) done_cnt++;
    end

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] s;
        logic [31:0] d;
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{we: 1'b0, addr: s, data: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: d, data: pat(s)});
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    task automatic drive_start(input logic [31:0] src, input logic [31:0] dst, input int n);
        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = src;
        dst_addr_i = dst;
        word_cnt_i = 16'(n);
        chk("busy_in_start_cycle", busy_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_cycle1", busy_o, 1);
    endtask

    // Latency is counted from the start cycle (cycle 0) to the done cycle.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input int lat, input int exp_cyc);
        int c;
        resp_lat = lat;
        push_copy(src, dst, n);
        drive_start(src, dst, n);
        c = 1;
        while (!done_o && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", done_o, 1);
        chk("done_latency", c, exp_cyc);
        chk("err_on_done", err_o, 0);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, 0);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int dc;
        rst        = 1'b1;
        start_i    = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        word_cnt_i = '0;
        dbus_ack_i = 1'b0;
        dbus_r_data_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_req", dbus_req_o, 0);
        chk("rst_addr", dbus_addr_o, 0);
        chk("rst_wen", dbus_w_en_o, 0);
        chk("rst_wdata", dbus_w_data_o, 0);
        rst = 1'b0;

        // 3 words, 1-cycle ack: 4 cycles per word, done in cycle 13
        run_copy(32'h0000_1000, 32'h8000_0000, 3, 1, 13);

        // zero count: done the cycle after start, no bus traffic at all
        resp_lat = 1;
        drive_start(32'h0000_2000, 32'h0000_3000, 0);
        chk("zero_done", done_o, 1);
        chk("zero_req", dbus_req_o, 0);
        @(negedge clk);
        chk("zero_done_off", done_o, 0);
        chk("zero_busy_off", busy_o, 0);

        // slow responder: 5 req cycles + ack cycle per access
        run_copy(32'h0000_4000, 32'h9000_0010, 2, 5, 25);

        // source wrap at the top of the address space; low bits ignored
        run_copy(32'hFFFF_FFFF, 32'h0001_0002, 2, 1, 9);

        // odd random-ish block
        run_copy(32'h0000_5004, 32'hA000_0100, 5, 2, 5 * 6 + 1);

        // reset during the second word's write
        resp_lat = 1;
        push_copy(32'h0000_6000, 32'hB000_0000, 3);
        drive_start(32'h0000_6000, 32'hB000_0000, 3);
        k = 0;
        while (!(dbus_req_o && dbus_w_en_o && dbus_addr_o == 32'hB000_0004) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reached", k < 100, 1);
        dc  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", dbus_req_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_done", done_o, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, dc);
        chk("rst_mid_idle_req", dbus_req_o, 0);
        exp_q.delete();
        run_copy(32'h0000_7000, 32'hC000_0000, 2, 1, 9);

        // responder never acks
        resp_lat = 0;
        push_copy(32'h0000_8000, 32'hD000_0000, 1);
        dc = done_cnt;
        drive_start(32'h0000_8000, 32'hD000_0000, 1);
        k = 1;
`ifdef BMEM_COPY_TIMEOUT_EN
        begin
            int c;
            c = 1;
            while (!err_o && c < 300) begin
                @(negedge clk);
                c++;
                if (dbus_req_o) k++;
            end
            chk("to_err_seen", err_o, 1);
            chk("to_req_cycles", k, 64);
            chk("to_no_done", done_cnt, dc);
            @(negedge clk);
            chk("to_err_one_cycle", err_o, 0);
            chk("to_busy_off", busy_o, 0);
        end
`else
        repeat (199) begin
            @(negedge clk);
            if (dbus_req_o) k++;
        end
        chk("hang_req_cycles", k, 200);
        chk("hang_err", err_o, 0);
        chk("hang_no_done", done_cnt, dc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        exp_q.delete();
        run_copy(32'h0000_9000, 32'hE000_0000, 1, 1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
